// File: rtl/alu_matrix_3x3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_matrix_3x3                                                  |
// | Brief    : 3x3 integer matrix ALU behind a select/data command port.       |
// |            Optional determinant unit enabled by `define MATRIX_DET_EN.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_matrix_3x3 #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [5:0]   sel,
   input  logic [W-1:0] eleIn,
   output logic [W-1:0] eleOut
);

   localparam logic [5:0] c_A_LAST   = 6'd8;
   localparam logic [5:0] c_B_FIRST  = 6'd9;
   localparam logic [5:0] c_B_LAST   = 6'd17;
   localparam logic [5:0] c_C_FIRST  = 6'd18;
   localparam logic [5:0] c_C_LAST   = 6'd26;
   localparam logic [5:0] c_RD_DET   = 6'd27;
   localparam logic [5:0] c_OP_TRANS = 6'd28;
   localparam logic [5:0] c_OP_ADD   = 6'd29;
   localparam logic [5:0] c_OP_SUB   = 6'd30;
   localparam logic [5:0] c_OP_MUL   = 6'd31;
   localparam logic [5:0] c_OP_SMUL  = 6'd32;
   localparam logic [5:0] c_OP_DET   = 6'd33;
   localparam logic [5:0] c_LD_S     = 6'd40;

   logic [W-1:0] r_a [9];
   logic [W-1:0] r_b [9];
   logic [W-1:0] r_c [9];
   logic [W-1:0] r_s;

   logic [W-1:0] w_trans [9];
   logic [W-1:0] w_add   [9];
   logic [W-1:0] w_sub   [9];
   logic [W-1:0] w_mul   [9];
   logic [W-1:0] w_smul  [9];

   logic [3:0]   w_a_idx;
   logic [3:0]   w_b_idx;
   logic [3:0]   w_c_idx;

   assign w_a_idx = sel[3:0];
   assign w_b_idx = 4'(sel - c_B_FIRST);
   assign w_c_idx = 4'(sel - c_C_FIRST);

   // Per-element result lanes; every operation result is available each cycle.
   for (genvar k = 0; k < 9; k++) begin : g_elem
      localparam int c_R = k / 3;
      localparam int c_C = k % 3;
      assign w_trans[k] = r_a[c_C*3 + c_R];
      assign w_add[k]   = r_a[k] + r_b[k];
      assign w_sub[k]   = r_a[k] - r_b[k];
      assign w_mul[k]   = (r_a[c_R*3]     * r_b[c_C])
                        + (r_a[c_R*3 + 1] * r_b[3 + c_C])
                        + (r_a[c_R*3 + 2] * r_b[6 + c_C]);
      assign w_smul[k]  = r_s * r_a[k];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 9; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_c[k] <= '0;
         end
         r_s <= '0;
      end else begin
         if (sel <= c_A_LAST) begin
            r_a[w_a_idx] <= eleIn;
         end
         if (sel >= c_B_FIRST && sel <= c_B_LAST) begin
            r_b[w_b_idx] <= eleIn;
         end
         if (sel == c_LD_S) begin
            r_s <= eleIn;
         end
         for (int k = 0; k < 9; k++) begin
            case (sel)
               c_OP_TRANS: r_c[k] <= w_trans[k];
               c_OP_ADD:   r_c[k] <= w_add[k];
               c_OP_SUB:   r_c[k] <= w_sub[k];
               c_OP_MUL:   r_c[k] <= w_mul[k];
               c_OP_SMUL:  r_c[k] <= w_smul[k];
               default:    r_c[k] <= r_c[k];
            endcase
         end
      end
   end

`ifdef MATRIX_DET_EN
   logic [W-1:0] r_d;
   logic [W-1:0] w_cof0;
   logic [W-1:0] w_cof1;
   logic [W-1:0] w_cof2;
   logic [W-1:0] w_det;

   // Row-0 cofactor expansion; modulo-2^W arithmetic makes signedness irrelevant.
   assign w_cof0 = (r_a[4] * r_a[8]) - (r_a[5] * r_a[7]);
   assign w_cof1 = (r_a[3] * r_a[8]) - (r_a[5] * r_a[6]);
   assign w_cof2 = (r_a[3] * r_a[7]) - (r_a[4] * r_a[6]);
   assign w_det  = (r_a[0] * w_cof0) - (r_a[1] * w_cof1) + (r_a[2] * w_cof2);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_d <= '0;
      end else if (sel == c_OP_DET) begin
         r_d <= w_det;
      end
   end
`endif

   always_comb begin
      eleOut = '0;
      if (sel >= c_C_FIRST && sel <= c_C_LAST) begin
         eleOut = r_c[w_c_idx];
      end
`ifdef MATRIX_DET_EN
      if (sel == c_RD_DET) begin
         eleOut = r_d;
      end
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_matrix_3x3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_matrix_3x3                                               |
// | Brief    : Directed self-checking bench for alu_matrix_3x3.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_alu_matrix_3x3;

   logic        clk;
   logic        reset;
   logic [5:0]  sel;
   logic [31:0] eleIn;
   logic [31:0] eleOut;

   int checks;
   int errors;

   logic [31:0] ma  [9];
   logic [31:0] mb  [9];
   logic [31:0] exp_c [9];

   alu_matrix_3x3 #(.W(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .sel    (sel),
      .eleIn  (eleIn),
      .eleOut (eleOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmd(input logic [5:0] s, input logic [31:0] d);
      sel   = s;
      eleIn = d;
      @(posedge clk);
      #1;
   endtask

   task automatic load_ab();
      for (int k = 0; k < 9; k++) cmd(6'(k), ma[k]);
      for (int k = 0; k < 9; k++) cmd(6'(k + 9), mb[k]);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cmd(6'd63, 32'hDEAD_BEEF);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         sel = 6'(18 + k);
         @(negedge clk);
         checks++;
         if (eleOut !== 32'd0) begin
            errors++;
            $display("FAIL reset_read sel=%0d got=%0d want=0", sel, eleOut);
         end
      end
   endtask

   task automatic test_basic_ops();
      ma = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
      mb = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
      load_ab();
      for (int op = 0; op < 3; op++) begin
         case (op)
            0: exp_c = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
            1: exp_c = '{0, 2, 4, 6, 8, 10, 12, 14, 16};
            default: exp_c = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
         endcase
         cmd(6'(28 + op), 32'd0);
         for (int k = 0; k < 9; k++) begin
            sel = 6'(18 + k);
            @(negedge clk);
            checks++;
            if (eleOut !== exp_c[k]) begin
               errors++;
               $display("FAIL op%0d C[%0d] got=%0d want=%0d", 28 + op, k, eleOut, exp_c[k]);
            end
         end
      end
   endtask

   task automatic test_mul_scalar_det0();
      exp_c = '{15, 18, 21, 42, 54, 66, 69, 90, 111};
      cmd(6'd31, 32'd0);
      for (int k = 0; k < 9; k++) begin
         sel = 6'(18 + k);
         @(negedge clk);
         checks++;
         if (eleOut !== exp_c[k]) begin
            errors++;
            $display("FAIL matmul C[%0d] got=%0d want=%0d", k, eleOut, exp_c[k]);
         end
      end
      cmd(6'd40, 32'd2);
      cmd(6'd32, 32'd0);
      exp_c = '{0, 2, 4, 6, 8, 10, 12, 14, 16};
      for (int k = 0; k < 9; k++) begin
         sel = 6'(18 + k);
         @(negedge clk);
         checks++;
         if (eleOut !== exp_c[k]) begin
            errors++;
            $display("FAIL smul2 C[%0d] got=%0d want=%0d", k, eleOut, exp_c[k]);
         end
      end
      cmd(6'd33, 32'd0);
      sel = 6'd27;
      @(negedge clk);
      checks++;
      if (eleOut !== 32'd0) begin
         errors++;
         $display("FAIL det_singular got=%0d want=0", eleOut);
      end
   endtask

   task automatic test_signed();
      ma = '{0, 2, 2, 3, 4, 8, 6, 17, 18};
      mb = '{10, 11, 12, 3, 4, 5, 6, 7, 0};
      load_ab();
      cmd(6'd30, 32'd0);
      exp_c = '{-10, -9, -10, 0, 0, 3, 0, 10, 18};
      for (int k = 0; k < 9; k++) begin
         sel = 6'(18 + k);
         @(negedge clk);
         checks++;
         if (eleOut !== exp_c[k]) begin
            errors++;
            $display("FAIL sub_signed C[%0d] got=%0d want=%0d", k, $signed(eleOut), $signed(exp_c[k]));
         end
      end
      // Holding the op for several cycles must give the same result.
      cmd(6'd31, 32'd0);
      cmd(6'd31, 32'd0);
      exp_c = '{18, 22, 10, 0, 0, 0, 0, 0, 0};
      for (int k = 0; k < 3; k++) begin
         sel = 6'(18 + k);
         @(negedge clk);
         checks++;
         if (eleOut !== exp_c[k]) begin
            errors++;
            $display("FAIL matmul_row0 C[%0d] got=%0d want=%0d", k, eleOut, exp_c[k]);
         end
      end
   endtask

   task automatic test_scalar_det();
      logic [31:0] exp_d;
      cmd(6'd40, 32'd5);
      cmd(6'd32, 32'd0);
      exp_c = '{0, 10, 10, 15, 20, 40, 30, 85, 90};
      for (int k = 0; k < 9; k++) begin
         sel = 6'(18 + k);
         @(negedge clk);
         checks++;
         if (eleOut !== exp_c[k]) begin
            errors++;
            $display("FAIL smul5 C[%0d] got=%0d want=%0d", k, eleOut, exp_c[k]);
         end
      end
      cmd(6'd33, 32'd0);
`ifdef MATRIX_DET_EN
      exp_d = 32'd42;
`else
      exp_d = 32'd0;
`endif
      sel = 6'd27;
      @(negedge clk);
      checks++;
      if (eleOut !== exp_d) begin
         errors++;
         $display("FAIL det got=%0d want=%0d", $signed(eleOut), $signed(exp_d));
      end
   endtask

   task automatic test_unused();
      logic [31:0] c0;
      c0 = 32'd0;
      cmd(6'd35, 32'hFFFF_FFFF);
      cmd(6'd63, 32'h1234_5678);
      cmd(6'd18, 32'hAAAA_5555);
      sel = 6'd35;
      @(negedge clk);
      checks++;
      if (eleOut !== 32'd0) begin
         errors++;
         $display("FAIL unused35_read got=%0d want=0", eleOut);
      end
      sel = 6'd63;
      @(negedge clk);
      checks++;
      if (eleOut !== 32'd0) begin
         errors++;
         $display("FAIL unused63_read got=%0d want=0", eleOut);
      end
      // C still holds 5*A from the previous scenario.
      exp_c = '{0, 10, 10, 15, 20, 40, 30, 85, 90};
      for (int k = 0; k < 9; k++) begin
         sel = 6'(18 + k);
         @(negedge clk);
         checks++;
         if (eleOut !== exp_c[k]) begin
            errors++;
            $display("FAIL unused_keep C[%0d] got=%0d want=%0d", k, eleOut, exp_c[k]);
         end
      end
      // A still intact: add with B must give A+B.
      cmd(6'd29, c0);
      exp_c = '{10, 13, 14, 6, 8, 13, 12, 24, 18};
      for (int k = 0; k < 9; k++) begin
         sel = 6'(18 + k);
         @(negedge clk);
         checks++;
         if (eleOut !== exp_c[k]) begin
            errors++;
            $display("FAIL unused_add C[%0d] got=%0d want=%0d", k, eleOut, exp_c[k]);
         end
      end
   endtask

   task automatic test_reset_mid();
      cmd(6'd33, 32'd0);
      reset = 1'b1;
      cmd(6'd29, 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         sel = 6'(18 + k);
         @(negedge clk);
         checks++;
         if (eleOut !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid sel=%0d got=%0d want=0", sel, eleOut);
         end
      end
      cmd(6'd40, 32'd0);
      cmd(6'd29, 32'd0);
      for (int k = 0; k < 9; k++) begin
         sel = 6'(18 + k);
         @(negedge clk);
         checks++;
         if (eleOut !== 32'd0) begin
            errors++;
            $display("FAIL reset_add C[%0d] got=%0d want=0", k, eleOut);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      sel    = 6'd63;
      eleIn  = 32'd0;
      @(posedge clk);
      #1;
      test_reset();
      test_basic_ops();
      test_mul_scalar_det0();
      test_signed();
      test_scalar_det();
      test_unused();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
